// File: rtl/irq_controller_pkg.sv
// Shared constants for the interrupt controller: register addresses, vector layout
// and the names of the request lines.
package irq_pkg;

   localparam logic [15:0] IF_ADDR    = 16'hFF0F;
   localparam logic [15:0] IE_ADDR    = 16'hFFFF;
   localparam logic [15:0] VEC_BASE   = 16'h0040;
   localparam logic [15:0] VEC_STRIDE = 16'd8;

   typedef enum logic [2:0] {
      VBLANK = 3'd0,
      STAT   = 3'd1,
      TIMER  = 3'd2,
      SERIAL = 3'd3,
      JOYPAD = 3'd4
   } irq_e;

endpackage

// File: rtl/irq_controller_if.sv
// MMU bus plus CPU interrupt handshake; master is the MMU/CPU side, slave is the
// interrupt controller.
interface irq_controller_if;

   logic [15:0] addr;
   logic [7:0]  wdata;
   logic        read_en;
   logic        write_en;
   logic [7:0]  rdata;
   logic        sel;
   logic        irq_pending;
   logic [2:0]  irq_index;
   logic [15:0] irq_vector;
   logic        irq_ack;
   logic [2:0]  ack_index;

   modport master (
      output addr, wdata, read_en, write_en, irq_ack, ack_index,
      input  rdata, sel, irq_pending, irq_index, irq_vector
   );

   modport slave (
      input  addr, wdata, read_en, write_en, irq_ack, ack_index,
      output rdata, sel, irq_pending, irq_index, irq_vector
   );

endinterface

// File: rtl/irq_edge_detect.sv
// Per-line request qualifier: rising-edge or level mode selected by EDGE_MASK.
// Produces the mask of IF bits to set this cycle.
module irq_edge_detect #(
   parameter int                 WIDTH     = 5,
   parameter logic [WIDTH-1:0]   EDGE_MASK = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] req,
   output logic [WIDTH-1:0] set_mask
);

   logic [WIDTH-1:0] req_prev;

   // Reset loads the live request so a line already high at release is not seen as an edge.
   always_ff @(posedge clk) begin
      req_prev <= req;
   end

   assign set_mask = (req & ~req_prev & EDGE_MASK) | (req & ~EDGE_MASK);

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller owning IF/IE: latches peripheral requests, exposes the
// registers on the MMU bus and presents the highest-priority enabled interrupt.
module irq_controller
   import irq_pkg::*;
#(
   parameter int                   NUM_IRQ   = 5,
   parameter logic [NUM_IRQ-1:0]   EDGE_MASK = {NUM_IRQ{1'b1}}
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] req,
   irq_controller_if.slave    bus
);

   logic [NUM_IRQ-1:0] if_q;
   logic [7:0]         ie_q;
   logic [NUM_IRQ-1:0] set_mask;
   logic [NUM_IRQ-1:0] ack_clr;
   logic [NUM_IRQ-1:0] pend;
   logic [7:0]         if_read;
   logic [2:0]         index_c;
   logic               hit_if;
   logic               hit_ie;

   irq_edge_detect #(
      .WIDTH     (NUM_IRQ),
      .EDGE_MASK (EDGE_MASK)
   ) u_edge (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .set_mask (set_mask)
   );

   assign hit_if = (bus.addr == IF_ADDR);
   assign hit_ie = (bus.addr == IE_ADDR);

   // An ack for an index beyond the implemented lines matches no bit and is ignored.
   always_comb begin
      ack_clr = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         ack_clr[i] = bus.irq_ack && (bus.ack_index == 3'(i));
      end
   end

   // Hardware set wins over ack, which wins over the CPU write.
   always_ff @(posedge clk) begin
      if (reset) begin
         if_q <= '0;
         ie_q <= '0;
      end else begin
         if_q <= ((bus.write_en && hit_if) ? bus.wdata[NUM_IRQ-1:0] : if_q) & ~ack_clr | set_mask;
         if (bus.write_en && hit_ie) begin
            ie_q <= bus.wdata;
         end
      end
   end

   // Lowest pending index wins; the downward scan leaves it as the final assignment.
   always_comb begin
      pend    = if_q & ie_q[NUM_IRQ-1:0];
      index_c = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (pend[i]) begin
            index_c = 3'(i);
         end
      end
   end

   always_comb begin
      if_read              = 8'hFF;
      if_read[NUM_IRQ-1:0] = if_q;
   end

   assign bus.sel         = hit_if || hit_ie;
   assign bus.rdata       = !bus.read_en ? 8'hFF :
                            hit_if       ? if_read :
                            hit_ie       ? ie_q    : 8'hFF;
   assign bus.irq_pending = |pend;
   assign bus.irq_index   = index_c;
   assign bus.irq_vector  = (|pend) ? (VEC_BASE + VEC_STRIDE * 16'(index_c)) : 16'h0000;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: one all-edge instance and one with line 0 in
// level mode, checked against hand-computed register and vector values.
module tb_irq_controller;
   import irq_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] req_e;
   logic [4:0] req_l;
   int         total = 0;
   int         bad   = 0;

   irq_controller_if bus_e ();
   irq_controller_if bus_l ();

   irq_controller #(.NUM_IRQ(5), .EDGE_MASK(5'b11111)) dut_e (
      .clk   (clk),
      .reset (reset),
      .req   (req_e),
      .bus   (bus_e.slave)
   );

   irq_controller #(.NUM_IRQ(5), .EDGE_MASK(5'b11110)) dut_l (
      .clk   (clk),
      .reset (reset),
      .req   (req_l),
      .bus   (bus_l.slave)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int cycles);
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic busWrite(input logic [15:0] a, input logic [7:0] d);
      bus_e.addr     = a;
      bus_e.wdata    = d;
      bus_e.write_en = 1'b1;
      applyStimulus(1);
      bus_e.write_en = 1'b0;
   endtask

   task automatic busRead(input logic [15:0] a);
      bus_e.addr    = a;
      bus_e.read_en = 1'b1;
      #1;
   endtask

   task automatic ack(input logic [2:0] idx);
      bus_e.irq_ack   = 1'b1;
      bus_e.ack_index = idx;
      applyStimulus(1);
      bus_e.irq_ack   = 1'b0;
   endtask

   initial begin
      reset          = 1'b1;
      req_e          = 5'b00001;
      req_l          = 5'b00001;
      bus_e.addr     = 16'h0000;
      bus_e.wdata    = 8'h00;
      bus_e.read_en  = 1'b0;
      bus_e.write_en = 1'b0;
      bus_e.irq_ack  = 1'b0;
      bus_e.ack_index = 3'd0;
      bus_l.addr     = 16'h0000;
      bus_l.wdata    = 8'h00;
      bus_l.read_en  = 1'b0;
      bus_l.write_en = 1'b0;
      bus_l.irq_ack  = 1'b0;
      bus_l.ack_index = 3'd0;
      applyStimulus(2);
      checkOutput("reset_pending", 16'(bus_e.irq_pending), 16'h0);
      checkOutput("reset_vector", bus_e.irq_vector, 16'h0000);
      checkOutput("reset_sel_idle", 16'(bus_e.sel), 16'h0);

      // Release with req[0] still high: no spurious edge.
      reset = 1'b0;
      applyStimulus(1);
      busRead(IF_ADDR);
      checkOutput("post_reset_if", 16'(bus_e.rdata), 16'h00E0);
      checkOutput("post_reset_sel", 16'(bus_e.sel), 16'h1);
      checkOutput("post_reset_pending", 16'(bus_e.irq_pending), 16'h0);
      checkOutput("post_reset_index", 16'(bus_e.irq_index), 16'h0);
      req_e = 5'b00000;

      busWrite(IE_ADDR, 8'h1F);
      busRead(IE_ADDR);
      checkOutput("ie_readback", 16'(bus_e.rdata), 16'h001F);

      req_e[TIMER] = 1'b1;
      applyStimulus(1);
      req_e = 5'b00000;
      busRead(IF_ADDR);
      checkOutput("timer_pending", 16'(bus_e.irq_pending), 16'h1);
      checkOutput("timer_index", 16'(bus_e.irq_index), 16'h2);
      checkOutput("timer_vector", bus_e.irq_vector, 16'h0050);
      checkOutput("timer_if", 16'(bus_e.rdata), 16'h00E4);
      ack(3'd2);
      checkOutput("timer_acked", 16'(bus_e.irq_pending), 16'h0);

      req_e = 5'b10001;
      applyStimulus(1);
      req_e = 5'b00000;
      checkOutput("prio_index", 16'(bus_e.irq_index), 16'h0);
      checkOutput("prio_vector", bus_e.irq_vector, 16'h0040);
      ack(3'd0);
      checkOutput("next_index", 16'(bus_e.irq_index), 16'h4);
      checkOutput("next_vector", bus_e.irq_vector, 16'h0060);
      ack(3'd4);
      checkOutput("all_acked", 16'(bus_e.irq_pending), 16'h0);

      // New edge, ack and CPU clear of IF in the same cycle: the set wins.
      req_e[STAT]    = 1'b1;
      bus_e.irq_ack  = 1'b1;
      bus_e.ack_index = 3'd1;
      busWrite(IF_ADDR, 8'h00);
      bus_e.irq_ack  = 1'b0;
      req_e          = 5'b00000;
      busRead(IF_ADDR);
      checkOutput("set_beats_ack_write", 16'(bus_e.rdata), 16'h00E2);
      ack(3'd1);

      // Write and ack together: ack clears from the written value.
      bus_e.irq_ack  = 1'b1;
      bus_e.ack_index = 3'd0;
      busWrite(IF_ADDR, 8'h1F);
      bus_e.irq_ack  = 1'b0;
      busRead(IF_ADDR);
      checkOutput("write_then_ack", 16'(bus_e.rdata), 16'h00FE);
      checkOutput("write_then_ack_idx", 16'(bus_e.irq_index), 16'h1);
      ack(3'd5);
      busRead(IF_ADDR);
      checkOutput("ack_out_of_range", 16'(bus_e.rdata), 16'h00FE);

      busWrite(IE_ADDR, 8'h00);
      checkOutput("masked_pending", 16'(bus_e.irq_pending), 16'h0);
      checkOutput("masked_vector", bus_e.irq_vector, 16'h0000);
      busWrite(IE_ADDR, 8'h08);
      checkOutput("ie_bit3_index", 16'(bus_e.irq_index), 16'h3);
      checkOutput("ie_bit3_vector", bus_e.irq_vector, 16'h0058);
      busWrite(IF_ADDR, 8'h00);

      busRead(16'hFF10);
      checkOutput("unmapped_sel", 16'(bus_e.sel), 16'h0);
      checkOutput("unmapped_rdata", 16'(bus_e.rdata), 16'h00FF);

      // Level line 0 re-asserts after a CPU clear until the request drops.
      bus_l.addr     = IF_ADDR;
      bus_l.read_en  = 1'b1;
      bus_l.wdata    = 8'h00;
      bus_l.write_en = 1'b1;
      applyStimulus(1);
      bus_l.write_en = 1'b0;
      #1;
      checkOutput("level_reasserts", 16'(bus_l.rdata), 16'h00E1);
      req_l          = 5'b00000;
      bus_l.write_en = 1'b1;
      applyStimulus(1);
      bus_l.write_en = 1'b0;
      applyStimulus(1);
      checkOutput("level_cleared", 16'(bus_l.rdata), 16'h00E0);

      // Reset overrides a concurrent IE write and request edge.
      bus_e.addr     = IE_ADDR;
      bus_e.wdata    = 8'h1F;
      bus_e.write_en = 1'b1;
      req_e          = 5'b00001;
      reset          = 1'b1;
      applyStimulus(1);
      bus_e.write_en = 1'b0;
      reset          = 1'b0;
      busRead(IE_ADDR);
      checkOutput("midreset_ie", 16'(bus_e.rdata), 16'h0000);
      applyStimulus(1);
      busRead(IF_ADDR);
      checkOutput("midreset_if", 16'(bus_e.rdata), 16'h00E0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
